uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115_200: line bit rate in baud.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..8: payload bits per frame.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2: stop bits per frame.
REQ-006 Parameter OVERSAMPLE, default 16: sample ticks per bit.
REQ-007 Port clk, input, 1 bit: the single clock; one clock, all logic on rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-009 Port data_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 Port data_out, output, DATA_BITS bits: received payload, LSB is the first bit received.
REQ-011 Port data_valid, output, 1 bit: data_out, parity_err and frame_err are valid.
REQ-012 Port data_ready, input, 1 bit: consumer accepts the word; a transfer occurs on a cycle with valid and ready both high.
REQ-013 Port data_out_done, output, 1 bit: single-cycle pulse when a frame completes.
REQ-014 Port parity_err, output, 1 bit: parity mismatch for the word presented on data_out.
REQ-015 Port frame_err, output, 1 bit: a stop bit was sampled low for the word presented on data_out.
REQ-016 Port overrun_err, output, 1 bit: single-cycle pulse when a completed frame is dropped.

Function
REQ-017 Baud generator: tick period = CLK_FREQ/(BAUDRATE*OVERSAMPLE), integer division; 54 clocks at the defaults.
REQ-018 Line sync: data_rx passes through 2 flops, both reset to 1; all decisions use the synced value.
REQ-019 Arming: the receiver arms only after the synced line has been high for at least one full tick; it is disarmed after reset and after any frame_err.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE -> START: armed and synced line falls 1 -> 0; the tick counter is restarted at this point.
REQ-022 Sampling: each bit is the majority vote of samples at ticks 7, 8 and 9 of 16 (scaled proportionally for other OVERSAMPLE values).
REQ-023 START -> IDLE if the start-bit vote is 1 (false start, no output); otherwise START -> DATA.
REQ-024 DATA: shift in DATA_BITS bits, LSB first; then go to PARITY if PARITY != 0, else go to STOP.
REQ-025 PARITY: parity_err = received parity bit XOR computed parity (odd or even over the payload).
REQ-026 STOP: sample STOP_BITS stop bits; any stop bit voted 0 sets frame_err.
REQ-027 Completion: at the sample point of the last stop bit, data_out_done pulses high for one cycle on the next clock; the state returns to IDLE in the same cycle.
REQ-028 Errored frames are still delivered, with their error flags attached.
REQ-029 Output: data_valid rises on the cycle data_out_done pulses, provided storage was free.
REQ-030 Output: data_out and both error flags hold stable while data_valid is high and data_ready is low.
REQ-031 Overrun: if a frame completes while storage is full, the new frame is dropped, the stored word is unchanged, and overrun_err pulses for one cycle with data_out_done.
REQ-032 Simultaneous events: a transfer (valid and ready high) in the same cycle as a completion frees the slot first; no overrun occurs.

Reset
REQ-033 On rst_n low: state = IDLE, disarmed, counters = 0, sync flops = 1.
REQ-034 On rst_n low: data_out = 0, data_valid = 0, data_out_done = 0, parity_err = 0, frame_err = 0, overrun_err = 0, and storage is emptied.
REQ-035 Reset mid-frame discards the partial frame; no output is produced for it.

Configuration
REQ-036 Macro UART_RX_FIFO_EN defined: storage is a 4-entry FIFO of {data, parity_err, frame_err}; overrun occurs only when all 4 entries are full.
REQ-037 Macro UART_RX_FIFO_EN undefined: storage is a single holding register; overrun occurs when it is occupied.

Structure
REQ-038 Package uart_pkg holds: the FSM state enum, the parity encoding constants, the divisor function, and the FIFO depth constant.
REQ-039 Sub-module uart_baud_gen produces the oversample tick and supports a restart input.

Verification
REQ-040 Scenario 1: defaults (8N1), bit period 8640 ns, send 0x55 -> data_out_done pulses once, data_out = 0x55, no error flags.
REQ-041 Scenario 2: PARITY = 2, send 0xA3 with parity bit 1 -> data_out = 0xA3, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
REQ-042 Scenario 3: send 0x3C with the stop bit low -> frame_err = 1 and data_out = 0x3C; line held low afterwards -> no further frames until the line is high for at least one tick.
REQ-043 Scenario 4: 2000 ns low glitch on an idle line -> no data_out_done, state returns to IDLE.
REQ-044 Scenario 5: data_ready held low, send 0x11, 0x22, ... -> without the macro, overrun_err pulses on the 2nd frame and data_out stays 0x11; with UART_RX_FIFO_EN, overrun_err pulses on the 5th frame and 0x11..0x44 drain in order.
REQ-045 Scenario 6: pulse rst_n low mid-way through bit 4 of a frame -> no output for that frame; the next frame, 0xA3, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, parity codes, divisor helper and FIFO depth for the UART receiver
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int FIFO_DEPTH = 4;

  // Clocks per oversample tick; clamped so a tiny ratio still yields a running tick.
  function automatic int baud_div(input int clk_freq, input int baudrate, input int oversample);
    int div;
    div = clk_freq / (baudrate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick generator with restart
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : zero the divider so the next tick lands DIV clocks later
//   tick       : one-cycle pulse every DIV clocks
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with valid/ready output storage
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_rx       : asynchronous serial line, idle high
//   data_out      : received payload, LSB first on the line
//   data_valid    : data_out / parity_err / frame_err are valid
//   data_ready    : consumer accepts the presented word
//   data_out_done : one-cycle pulse per completed frame
//   parity_err    : parity mismatch of the presented word
//   frame_err     : a stop bit of the presented word was low
//   overrun_err   : one-cycle pulse when a completed frame is dropped
// Build option: UART_RX_FIFO_EN selects a 4-entry FIFO instead of a single holding register.
`timescale 1ns/1ps
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 data_out_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int ACW   = $clog2(DIV + 1);
  localparam int TCW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int S_LO  = (7 * OVERSAMPLE) / 16;
  localparam int S_MID = OVERSAMPLE / 2;
  localparam int S_HI  = (9 * OVERSAMPLE) / 16;
  localparam int EW    = DATA_BITS + 2;

  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [ACW-1:0]       arm_cnt_q, arm_cnt_d;
  logic                 armed_q, armed_d;
  uart_state_t          state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                 s_lo_q, s_lo_d, s_mid_q, s_mid_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 done_q, done_d, overrun_q, overrun_d;

  logic          rx_s, tick, start_det, bit_evt, bit_val, ferr_now, exp_par;
  logic          push, frame_fail, pop, accept;
  logic [EW-1:0] push_word;

  assign rx_s      = sync2_q;
  assign start_det = (state_q == ST_IDLE) && armed_q && rx_prev_q && !rx_s;
  assign exp_par   = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;
  assign push_word = {shift_q, perr_q, ferr_now};

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_det),
    .tick    (tick)
  );

  always_comb begin
    sync1_d    = data_rx;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    arm_cnt_d  = arm_cnt_q;
    armed_d    = armed_q;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    s_lo_d     = s_lo_q;
    s_mid_d    = s_mid_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    bit_evt    = 1'b0;
    bit_val    = 1'b0;
    ferr_now   = ferr_q;
    push       = 1'b0;
    frame_fail = 1'b0;

    // Arm once the line has stayed high for DIV consecutive clocks.
    if (!rx_s) begin
      arm_cnt_d = '0;
    end else if (arm_cnt_q != ACW'(DIV)) begin
      arm_cnt_d = arm_cnt_q + ACW'(1);
    end
    if (rx_s && (arm_cnt_q == ACW'(DIV - 1))) begin
      armed_d = 1'b1;
    end

    // Bit decision is a 2-of-3 vote; the third sample is the live line at S_HI.
    if ((state_q != ST_IDLE) && tick) begin
      tick_cnt_d = (tick_cnt_q == TCW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + TCW'(1);
      if (tick_cnt_q == TCW'(S_LO))  s_lo_d  = rx_s;
      if (tick_cnt_q == TCW'(S_MID)) s_mid_d = rx_s;
      if (tick_cnt_q == TCW'(S_HI)) begin
        bit_evt = 1'b1;
        bit_val = (s_lo_q & s_mid_q) | (s_lo_q & rx_s) | (s_mid_q & rx_s);
      end
    end

    // State advances at each vote; the free-running tick count keeps later
    // votes centred in the following bits.
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (bit_evt) begin
          state_d   = bit_val ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_evt) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_evt) begin
          perr_d  = bit_val ^ exp_par;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_evt) begin
          ferr_now = ferr_q | ~bit_val;
          ferr_d   = ferr_now;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            push       = 1'b1;
            frame_fail = ferr_now;
            state_d    = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A framing error means we may be mid-stream; wait for a fresh idle tick.
    if (frame_fail) begin
      armed_d   = 1'b0;
      arm_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      s_lo_q     <= 1'b0;
      s_mid_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_prev_q  <= rx_prev_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      s_lo_q     <= s_lo_d;
      s_mid_q    <= s_mid_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out_done = done_q;
  assign overrun_err   = overrun_q;

`ifdef UART_RX_FIFO_EN
  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    pop    = (cnt_q != '0) & data_ready;
    accept = push & ((cnt_q != CW'(FIFO_DEPTH)) | pop);
    mem_d  = mem_q;
    if (accept) mem_d[wr_q] = push_word;
    wr_d      = accept ? wr_q + PW'(1) : wr_q;
    rd_d      = pop ? rd_q + PW'(1) : rd_q;
    cnt_d     = cnt_q + CW'(accept) - CW'(pop);
    done_d    = push;
    overrun_d = push & ~accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_valid = (cnt_q != '0);
  assign {data_out, parity_err, frame_err} = mem_q[rd_q];
`else
  logic [EW-1:0] hold_q, hold_d;
  logic          full_q, full_d;

  // A same-cycle transfer frees the register before the new frame lands.
  always_comb begin
    pop    = full_q & data_ready;
    accept = push & (~full_q | pop);
    hold_d = accept ? push_word : hold_q;
    full_d = full_q;
    if (accept) begin
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
    done_d    = push;
    overrun_d = push & ~accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign data_valid = full_q;
  assign {data_out, parity_err, frame_err} = hold_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg (default 8N1 instance and fast 8E1 instance)
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam time BIT_A = 8640ns;
  localparam time BIT_P = 640ns;

  logic clk = 1'b0;
  always #5ns clk = ~clk;

  logic       rst_n, rx_a, rx_p, rdy_a, rdy_p;
  logic [7:0] do_a, do_p;
  logic       dv_a, dd_a, pe_a, fe_a, oe_a;
  logic       dv_p, dd_p, pe_p, fe_p, oe_p;

  uart_rx_cfg dut_a (
    .clk(clk), .rst_n(rst_n), .data_rx(rx_a), .data_out(do_a), .data_valid(dv_a),
    .data_ready(rdy_a), .data_out_done(dd_a), .parity_err(pe_a), .frame_err(fe_a),
    .overrun_err(oe_a)
  );

  uart_rx_cfg #(.BAUDRATE(1_562_500), .PARITY(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .data_rx(rx_p), .data_out(do_p), .data_valid(dv_p),
    .data_ready(rdy_p), .data_out_done(dd_p), .parity_err(pe_p), .frame_err(fe_p),
    .overrun_err(oe_p)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  int checks = 0;
  int failures = 0;
  int done_a = 0, done_p = 0, ovr_a = 0, ovr_p = 0;
  int exp_done_a = 0, exp_done_p = 0, exp_ovr_p = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every transfer and counts pulses.
  initial begin
    exp_t e;
    logic prev_a, prev_p;
    prev_a = 1'b0;
    prev_p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dd_a) begin done_a++; chk("a_done_single_cycle", 32'(prev_a), 32'd0); end
        if (dd_p) begin done_p++; chk("p_done_single_cycle", 32'(prev_p), 32'd0); end
        if (oe_a) ovr_a++;
        if (oe_p) begin ovr_p++; chk("p_overrun_with_done", 32'(dd_p), 32'd1); end
        if (dv_a && rdy_a) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_word", 32'(do_a), 32'hFFFF_FFFF);
          end else begin
            e = q_a.pop_front();
            chk("a_data", 32'(do_a), 32'(e.data));
            chk("a_parity_err", 32'(pe_a), 32'(e.perr));
            chk("a_frame_err", 32'(fe_a), 32'(e.ferr));
          end
        end
        if (dv_p && rdy_p) begin
          if (q_p.size() == 0) begin
            chk("p_unexpected_word", 32'(do_p), 32'hFFFF_FFFF);
          end else begin
            e = q_p.pop_front();
            chk("p_data", 32'(do_p), 32'(e.data));
            chk("p_parity_err", 32'(pe_p), 32'(e.perr));
            chk("p_frame_err", 32'(fe_p), 32'(e.ferr));
          end
        end
        prev_a = dd_a;
        prev_p = dd_p;
      end else begin
        prev_a = 1'b0;
        prev_p = 1'b0;
      end
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic par,
                      input logic stop, input logic idle);
    time bt;
    bt = sel ? BIT_P : BIT_A;
    drive(sel, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      #(bt);
    end
    if (sel) begin
      drive(sel, par);
      #(bt);
    end
    drive(sel, stop);
    #(bt);
    drive(sel, idle);
    #(bt);
  endtask

  task automatic wait_drain(input bit sel, input int max_cyc);
    int n;
    n = 0;
    while (((sel ? q_p.size() : q_a.size()) != 0) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "p_drain_left" : "a_drain_left", 32'(sel ? q_p.size() : q_a.size()), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    rdy_a = 1'b1;
    rdy_p = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_a_data_out", 32'(do_a), 32'd0);
    chk("rst_a_valid", 32'(dv_a), 32'd0);
    chk("rst_a_done", 32'(dd_a), 32'd0);
    chk("rst_a_parity_err", 32'(pe_a), 32'd0);
    chk("rst_a_frame_err", 32'(fe_a), 32'd0);
    chk("rst_a_overrun", 32'(oe_a), 32'd0);
    chk("rst_p_data_out", 32'(do_p), 32'd0);
    chk("rst_p_valid", 32'(dv_p), 32'd0);
    chk("rst_p_done", 32'(dd_p), 32'd0);
    chk("rst_p_parity_err", 32'(pe_p), 32'd0);
    chk("rst_p_frame_err", 32'(fe_p), 32'd0);
    chk("rst_p_overrun", 32'(oe_p), 32'd0);
    #(BIT_A);

    // Default 8N1 frame.
    q_a.push_back(mk(8'h55, 1'b0, 1'b0));
    exp_done_a++;
    send(1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, 20000);
    chk("s1_done_count", 32'(done_a), 32'(exp_done_a));

    // 2000 ns glitch on an idle line is a false start.
    rx_a = 1'b0;
    #2000ns;
    rx_a = 1'b1;
    #(2 * BIT_A);
    chk("s4_glitch_done_count", 32'(done_a), 32'(exp_done_a));
    q_a.push_back(mk(8'hC9, 1'b0, 1'b0));
    exp_done_a++;
    send(1'b0, 8'hC9, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, 20000);
    chk("s4_after_glitch_done_count", 32'(done_a), 32'(exp_done_a));

    // Even parity: 0xA3 has four ones, so parity bit 1 is wrong and 0 is right.
    q_p.push_back(mk(8'hA3, 1'b1, 1'b0));
    exp_done_p++;
    send(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1);
    q_p.push_back(mk(8'hA3, 1'b0, 1'b0));
    exp_done_p++;
    send(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b1, 2000);
    chk("s2_done_count", 32'(done_p), 32'(exp_done_p));

    // Stop bit low, then the line stays low; a sub-tick high blip must not rearm.
    q_p.push_back(mk(8'h3C, 1'b0, 1'b1));
    exp_done_p++;
    send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_drain(1'b1, 2000);
    #(3 * BIT_P);
    rx_p = 1'b1;
    #20ns;
    rx_p = 1'b0;
    #(12 * BIT_P);
    chk("s3_no_frame_while_low", 32'(done_p), 32'(exp_done_p));
    rx_p = 1'b1;
    #(2 * BIT_P);
    q_p.push_back(mk(8'h5A, 1'b0, 1'b0));
    exp_done_p++;
    send(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b1, 2000);
    chk("s3_rearm_done_count", 32'(done_p), 32'(exp_done_p));

    // Back-pressure: storage fills, later frames overrun, stored word holds.
    rdy_p = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(8'h11 * i);
`ifdef UART_RX_FIFO_EN
      if (i <= 4) q_p.push_back(mk(d, 1'b0, 1'b0));
      else        exp_ovr_p++;
`else
      if (i == 1) q_p.push_back(mk(d, 1'b0, 1'b0));
      else        exp_ovr_p++;
`endif
      exp_done_p++;
      send(1'b1, d, ^d, 1'b1, 1'b1);
      chk("s5_overrun_count", 32'(ovr_p), 32'(exp_ovr_p));
      chk("s5_hold_data", 32'(do_p), 32'h11);
      chk("s5_hold_valid", 32'(dv_p), 32'd1);
    end
    rdy_p = 1'b1;
    wait_drain(1'b1, 2000);
    chk("s5_done_count", 32'(done_p), 32'(exp_done_p));

    // Reset in the middle of data bit 4 discards the partial frame.
    d = 8'h0F;
    rx_p = 1'b0;
    #(BIT_P);
    for (int i = 0; i < 4; i++) begin
      rx_p = d[i];
      #(BIT_P);
    end
    rx_p = d[4];
    #(BIT_P / 2);
    rst_n = 1'b0;
    #30ns;
    rst_n = 1'b1;
    rx_p = 1'b1;
    #(3 * BIT_P);
    chk("s6_no_partial_frame", 32'(done_p), 32'(exp_done_p));
    chk("s6_p_valid_after_reset", 32'(dv_p), 32'd0);
    chk("s6_a_data_after_reset", 32'(do_a), 32'd0);
    q_p.push_back(mk(8'hA3, 1'b0, 1'b0));
    exp_done_p++;
    send(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b1, 2000);
    chk("s6_done_count", 32'(done_p), 32'(exp_done_p));
    chk("final_a_overrun_count", 32'(ovr_a), 32'd0);
    chk("final_a_done_count", 32'(done_a), 32'(exp_done_a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
